// File: rtl/rvvi_retire_tracer.sv
// RVVI trace producer: retire records pass through a DEPTH-entry FIFO into a registered output stage.
// Latency one edge from enqueue to out_valid, zero-bubble; in_ready = !full, independent of out_ready.
module rvvi_retire_tracer #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_insn,
    input  logic                       in_trap,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [ILEN-1:0]            out_insn,
    output logic                       out_trap,
    output logic                       out_compressed,
    output logic [63:0]                out_order,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic            compressed;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          in_rec;
    rec_t          head_q;
    rec_t          head_n;
    logic [PW-1:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic          full, push, pop, valid_n;

    // Compressed encodings only define the low halfword; clear the rest.
    always_comb begin
        in_rec.pc         = in_pc;
        in_rec.trap       = in_trap;
        in_rec.compressed = (in_insn[1:0] != 2'b11);
        in_rec.insn       = in_rec.compressed ? {{(ILEN-16){1'b0}}, in_insn[15:0]} : in_insn;
    end

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign wr_n     = wr_ptr + PW'(push);
    assign rd_n     = rd_ptr + PW'(pop);
    assign count    = wr_ptr - rd_ptr;
    assign valid_n  = (rd_n != wr_n);

    // The next head is the incoming record when it lands exactly at the new read slot.
    always_comb begin
        head_n = head_q;
        if (valid_n) begin
            if (rd_n == wr_ptr)
                head_n = in_rec;
            else
                head_n = mem[rd_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_rec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_q    <= '0;
            out_valid <= 1'b0;
            out_order <= 64'd1;
        end else begin
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            head_q    <= head_n;
            out_valid <= valid_n;
            if (pop)
                out_order <= out_order + 64'd1;
        end
    end

    assign out_pc         = head_q.pc;
    assign out_insn       = head_q.insn;
    assign out_trap       = head_q.trap;
    assign out_compressed = head_q.compressed;

endmodule

// File: doc/rvvi_retire_tracer.md
# rvvi_retire_tracer

Producer side of the RVVI trace interface: accepts one retired-instruction record per cycle from the core's writeback stage and drives the `valid`/`order`/`insn`/`pc_rdata`/`trap` trace signals that coverage and checker consumers sample. A small FIFO decouples core retirement from a consumer that may stall. Compressed instructions are normalised before they reach the trace, so consumers never see stale upper halfwords.

## Interface
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  retire record present.
- in_ready  out  1  record accepted when in_valid && in_ready; equals !full; does not depend on out_ready.
- in_pc  in  XLEN  PC of retired instruction.
- in_insn  in  ILEN  raw fetched instruction bits.
- in_trap  in  1  instruction trapped.
- out_valid  out  1  trace record valid (drives rvvi valid[0][0]).
- out_ready  in  1  consumer accepts; tie high for a non-stalling consumer.
- out_pc  out  XLEN  pc_rdata.
- out_insn  out  ILEN  normalised instruction.
- out_trap  out  1  trap flag.
- out_compressed  out  1  record is a 16-bit instruction.
- out_order  out  64  retirement order number of the presented record.
- count  out  $clog2(DEPTH)+1  entries held, including the presented one.

## Operation
- Enqueue on in_valid && in_ready. Normalisation happens at enqueue:
  - in_insn[1:0] != 2'b11 → stored insn = {16'b0, in_insn[15:0]}, compressed = 1.
  - Otherwise insn stored unchanged, compressed = 0.
- The FIFO is circular, with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Pointers wrap naturally modulo 2·DEPTH.
- The output stage is a register fed from the FIFO head.
  - out_* always reflect the head entry while out_valid = 1.
  - out_valid = !empty.
- Dequeue on out_valid && out_ready.
  - rd_ptr advances; out_order increments by 1.
- Order counter:
  - out_order = 1 for the first record after reset.
  - Strictly +1 per dequeue. Never skips, never repeats.
  - 64-bit wrap from all-ones to 0 is permitted.
- Stall: while out_valid && !out_ready, all out_* hold stable.
- Simultaneous enqueue and dequeue:
  - Allowed whenever !full; count unchanged.
  - When full, in_ready = 0, so only the dequeue occurs. in_ready rises the cycle after.
- No record is ever dropped. Back-pressure to the core is the only overflow mechanism.
- in_valid && !in_ready is a core stall, not an error. The record must be held by the core.
- Trapped instructions are traced like any other record, with out_trap = 1, and consume an order number.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - out_valid = 0, in_ready = 1, count = 0, out_order = 1.
  - out_pc = 0, out_insn = 0, out_trap = 0, out_compressed = 0.
  - Pointers = 0.
- Latency: a record enqueued at edge N into an empty FIFO has out_valid = 1 after edge N; zero-bubble.
- Throughput: one record per cycle sustained when out_ready = 1.
- count updates on the same edge as the enqueue or dequeue that changes it.
- Reset mid-stream: all queued records are discarded immediately. No partial record appears on out_* after reset asserts.

## Test plan
- Reset: assert reset with 3 records queued → same cycle out_valid = 0, count = 0, in_ready = 1; first post-reset record has out_order = 1.
- Single 32-bit: in_pc = 0x8000_0000, in_insn = 0x0010_0093, in_trap = 0 → next cycle out_valid = 1, out_insn = 0x0010_0093, out_compressed = 0, out_order = 1.
- Compressed trim: in_insn = 0xDEAD_4501 → out_insn = 0x0000_4501, out_compressed = 1. Then in_insn = 0x1234_0003 → unchanged, out_compressed = 0.
- Back-pressure: out_ready = 0, push 5 records with DEPTH = 4 → after 4, in_ready = 0 and count = 4, out_* stable at record 1. Raise out_ready → records emerge in order with out_order 1..4; the 5th is accepted the cycle after the first dequeue.
- Full push/pop: full FIFO, out_ready = 1, in_valid = 1 → no enqueue that cycle, count = 3. Next cycle in_ready = 1 and simultaneous push/pop holds count = 3. Run 2·DEPTH+3 records to cover pointer wrap; order is contiguous.
- Trap: record with in_trap = 1 between two normal records → out_trap = 1 only on the middle record; orders 1, 2, 3 contiguous.
